// File: rtl/roce_pkg.sv
// Shared RoCEv2 definitions used by the minimal TX stack and the ACK receiver.
package roce_pkg;

    localparam logic [7:0] RC_RDMA_WRITE_FIRST    = 8'h06;
    localparam logic [7:0] RC_RDMA_WRITE_MIDDLE   = 8'h07;
    localparam logic [7:0] RC_RDMA_WRITE_LAST     = 8'h08;
    localparam logic [7:0] RC_RDMA_WRITE_LAST_IMM = 8'h09;
    localparam logic [7:0] RC_RDMA_WRITE_ONLY     = 8'h0A;
    localparam logic [7:0] RC_RDMA_WRITE_ONLY_IMM = 8'h0B;
    localparam logic [7:0] RC_ACK                 = 8'h11;

    localparam logic [15:0] ROCE_UDP_PORT = 16'd4791;

    localparam int UDP_HDR_LEN = 8;
    localparam int BTH_LEN     = 12;
    localparam int AETH_LEN    = 4;
    localparam int ICRC_LEN    = 4;
    localparam logic [15:0] ACK_UDP_LENGTH = 16'(UDP_HDR_LEN + BTH_LEN + AETH_LEN + ICRC_LEN);

    localparam int         AETH_SYN_TYPE_HI = 6;
    localparam int         AETH_SYN_TYPE_LO = 5;
    localparam logic [1:0] AETH_TYPE_ACK    = 2'b00;
    localparam logic [1:0] AETH_TYPE_NAK    = 2'b11;

    // ST_INIT holds header ready low for the first cycle after reset release.
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_BTH,
        ST_AETH,
        ST_TAIL
    } rx_state_e;

endpackage

// File: rtl/roce_ack_rx_64.sv
// RoCEv2 ACKNOWLEDGE receiver: parses BTH+AETH from a 64-bit UDP payload stream
// and presents PSN/syndrome/MSN; all other traffic is consumed and dropped.
module roce_ack_rx_64
    import roce_pkg::*;
#(
    parameter int          DATA_WIDTH       = 64,
    parameter int          KEEP_WIDTH       = DATA_WIDTH / 8,
    parameter logic [15:0] ROCE_UDP_PORT    = roce_pkg::ROCE_UDP_PORT,
    parameter int          CHECK_UDP_LENGTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [23:0]           loc_qpn,
    input  logic                  s_udp_hdr_valid,
    output logic                  s_udp_hdr_ready,
    input  logic [31:0]           s_ip_source_ip,
    input  logic [15:0]           s_udp_source_port,
    input  logic [15:0]           s_udp_dest_port,
    input  logic [15:0]           s_udp_length,
    input  logic [DATA_WIDTH-1:0] s_udp_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_udp_payload_axis_tkeep,
    input  logic                  s_udp_payload_axis_tvalid,
    output logic                  s_udp_payload_axis_tready,
    input  logic                  s_udp_payload_axis_tlast,
    input  logic                  s_udp_payload_axis_tuser,
    output logic                  m_ack_valid,
    input  logic                  m_ack_ready,
    output logic [23:0]           m_ack_psn,
    output logic [7:0]            m_ack_syndrome,
    output logic [23:0]           m_ack_msn,
    output logic [31:0]           m_ack_src_ip,
    output logic                  busy,
    output logic                  error_drop,
    output logic                  error_payload_early_termination
);

    if (DATA_WIDTH != 64) begin : g_bad_width
        $error("roce_ack_rx_64 supports DATA_WIDTH=64 only");
    end

    rx_state_e   state_q, state_d;
    logic        pkt_ok_q, pkt_ok_d;
    logic        bad_q, bad_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [23:0] psn_q, psn_d;
    logic [7:0]  syn_q, syn_d;
    logic [23:0] msn_q, msn_d;
    logic        ack_valid_q, ack_valid_d;
    logic [23:0] ack_psn_q, ack_psn_d;
    logic [7:0]  ack_syn_q, ack_syn_d;
    logic [23:0] ack_msn_q, ack_msn_d;
    logic [31:0] ack_ip_q, ack_ip_d;
    logic        err_drop_q, err_drop_d;
    logic        err_early_q, err_early_d;

    logic        hdr_ready, pay_ready, beat, beat_bad, hdr_ok, bth_ok;
    logic [63:0] d;

    // Source port and byte enables carry nothing this parser needs.
    logic unused_inputs;
    assign unused_inputs = ^{s_udp_source_port, s_udp_payload_axis_tkeep};

    assign d = s_udp_payload_axis_tdata;

    always_comb begin
        hdr_ready = (state_q == ST_IDLE) && (!ack_valid_q || m_ack_ready);
        pay_ready = (state_q == ST_BTH) || (state_q == ST_AETH) || (state_q == ST_TAIL);
        beat      = s_udp_payload_axis_tvalid && pay_ready;
        beat_bad  = bad_q || s_udp_payload_axis_tuser;
        hdr_ok    = (s_udp_dest_port == ROCE_UDP_PORT) &&
                    ((CHECK_UDP_LENGTH == 0) || (s_udp_length == ACK_UDP_LENGTH));
        // Multi-byte fields arrive MSB first, so byte 5 is the top of the QPN.
        bth_ok    = (d[7:0] == RC_ACK) && ({d[47:40], d[55:48], d[63:56]} == loc_qpn);

        state_d     = state_q;
        pkt_ok_d    = pkt_ok_q;
        bad_d       = bad_q;
        src_ip_d    = src_ip_q;
        psn_d       = psn_q;
        syn_d       = syn_q;
        msn_d       = msn_q;
        ack_valid_d = ack_valid_q && !m_ack_ready;
        ack_psn_d   = ack_psn_q;
        ack_syn_d   = ack_syn_q;
        ack_msn_d   = ack_msn_q;
        ack_ip_d    = ack_ip_q;
        err_drop_d  = 1'b0;
        err_early_d = 1'b0;

        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (s_udp_hdr_valid && hdr_ready) begin
                    src_ip_d = s_ip_source_ip;
                    pkt_ok_d = hdr_ok;
                    bad_d    = 1'b0;
                    state_d  = ST_BTH;
                end
            end
            ST_BTH: begin
                if (beat) begin
                    bad_d    = beat_bad;
                    pkt_ok_d = pkt_ok_q && bth_ok;
                    if (s_udp_payload_axis_tlast) begin
                        err_drop_d  = 1'b1;
                        err_early_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_AETH;
                    end
                end
            end
            ST_AETH: begin
                if (beat) begin
                    bad_d = beat_bad;
                    psn_d = {d[15:8], d[23:16], d[31:24]};
                    syn_d = d[39:32];
                    msn_d = {d[47:40], d[55:48], d[63:56]};
                    if (s_udp_payload_axis_tlast) begin
                        err_drop_d  = 1'b1;
                        err_early_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                if (beat) begin
                    bad_d = beat_bad;
                    if (s_udp_payload_axis_tlast) begin
                        // Header gating guarantees the output register is free here.
                        if (pkt_ok_q && !beat_bad) begin
                            ack_valid_d = 1'b1;
                            ack_psn_d   = psn_q;
                            ack_syn_d   = syn_q;
                            ack_msn_d   = msn_q;
                            ack_ip_d    = src_ip_q;
                        end else begin
                            err_drop_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            pkt_ok_q    <= 1'b0;
            bad_q       <= 1'b0;
            ack_valid_q <= 1'b0;
            ack_psn_q   <= '0;
            ack_syn_q   <= '0;
            ack_msn_q   <= '0;
            ack_ip_q    <= '0;
            err_drop_q  <= 1'b0;
            err_early_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_ok_q    <= pkt_ok_d;
            bad_q       <= bad_d;
            ack_valid_q <= ack_valid_d;
            ack_psn_q   <= ack_psn_d;
            ack_syn_q   <= ack_syn_d;
            ack_msn_q   <= ack_msn_d;
            ack_ip_q    <= ack_ip_d;
            err_drop_q  <= err_drop_d;
            err_early_q <= err_early_d;
        end
    end

    // Shadow fields are only consumed after being written in the same packet.
    always_ff @(posedge clk) begin
        src_ip_q <= src_ip_d;
        psn_q    <= psn_d;
        syn_q    <= syn_d;
        msn_q    <= msn_d;
    end

    assign s_udp_hdr_ready                 = hdr_ready;
    assign s_udp_payload_axis_tready       = pay_ready;
    assign busy                            = pay_ready;
    assign m_ack_valid                     = ack_valid_q;
    assign m_ack_psn                       = ack_psn_q;
    assign m_ack_syndrome                  = ack_syn_q;
    assign m_ack_msn                       = ack_msn_q;
    assign m_ack_src_ip                    = ack_ip_q;
    assign error_drop                      = err_drop_q;
    assign error_payload_early_termination = err_early_q;

endmodule

// File: tb/tb_roce_ack_rx_64.sv
// Self-checking bench for roce_ack_rx_64: directed vector table, corner sequences
// and randomized packets against a packet-level reference model.
module tb_roce_ack_rx_64;

    localparam logic [23:0] LOC_QPN = 24'h000016;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hdr_valid = 1'b0, hdr_ready;
    logic [31:0] src_ip = '0;
    logic [15:0] src_port = '0, dst_port = '0, udp_len = '0;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic        tvalid = 1'b0, tready, tlast = 1'b0, tuser = 1'b0;
    logic        ack_valid, ack_ready = 1'b1;
    logic [23:0] ack_psn, ack_msn;
    logic [7:0]  ack_syn;
    logic [31:0] ack_ip;
    logic        busy, err_drop, err_early;

    always #5 clk = ~clk;

    roce_ack_rx_64 dut (
        .clk(clk), .rst_n(rst_n), .loc_qpn(LOC_QPN),
        .s_udp_hdr_valid(hdr_valid), .s_udp_hdr_ready(hdr_ready),
        .s_ip_source_ip(src_ip), .s_udp_source_port(src_port),
        .s_udp_dest_port(dst_port), .s_udp_length(udp_len),
        .s_udp_payload_axis_tdata(tdata), .s_udp_payload_axis_tkeep(tkeep),
        .s_udp_payload_axis_tvalid(tvalid), .s_udp_payload_axis_tready(tready),
        .s_udp_payload_axis_tlast(tlast), .s_udp_payload_axis_tuser(tuser),
        .m_ack_valid(ack_valid), .m_ack_ready(ack_ready),
        .m_ack_psn(ack_psn), .m_ack_syndrome(ack_syn), .m_ack_msn(ack_msn),
        .m_ack_src_ip(ack_ip), .busy(busy), .error_drop(err_drop),
        .error_payload_early_termination(err_early)
    );

    typedef struct {
        logic [15:0] port;
        logic [15:0] len;
        logic [7:0]  opcode;
        logic [23:0] qp;
        logic [23:0] psn;
        logic [7:0]  syn;
        logic [23:0] msn;
        logic [31:0] ip;
        int          nbeats;
        int          tuser_beat;
    } pkt_t;

    typedef struct {
        pkt_t p;
        int   gap;
        bit   exp_ack;
        bit   exp_drop;
        bit   exp_early;
    } vec_t;

    int n_checks = 0, n_errors = 0;
    int drop_cnt = 0, early_cnt = 0, ack_cnt = 0;
    int exp_drop_tot = 0, exp_early_tot = 0, exp_ack_tot = 0;
    logic [87:0] exp_q[$];
    logic [87:0] hold_val;
    bit          hold_pend = 0;
    bit          bp_done;
    vec_t        vecs[12];

    function automatic pkt_t mk(logic [15:0] port, logic [15:0] len, logic [7:0] op,
                                logic [23:0] qp, logic [23:0] psn, logic [7:0] syn,
                                logic [23:0] msn, logic [31:0] ip, int nb, int tub);
        pkt_t p;
        p.port = port; p.len = len; p.opcode = op; p.qp = qp; p.psn = psn;
        p.syn = syn; p.msn = msn; p.ip = ip; p.nbeats = nb; p.tuser_beat = tub;
        return p;
    endfunction

    // Reference: an ACK is delivered iff every acceptance rule holds.
    function automatic bit model_ok(pkt_t p);
        return (p.port == 16'd4791) && (p.len == 16'd28) && (p.opcode == 8'h11) &&
               (p.qp == LOC_QPN) && (p.tuser_beat < 0) && (p.nbeats >= 3);
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pulse counters, output-hold rule and scoreboard of delivered ACKs.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
        end else begin
            if (err_drop) drop_cnt++;
            if (err_early) early_cnt++;
            if (hold_pend) begin
                n_checks++;
                if (!ack_valid || {ack_psn, ack_syn, ack_msn, ack_ip} !== hold_val) begin
                    n_errors++;
                    $display("FAIL hold: valid %0b fields %0h expected %0h", ack_valid,
                             {ack_psn, ack_syn, ack_msn, ack_ip}, hold_val);
                end
            end
            hold_pend = ack_valid && !ack_ready;
            hold_val  = {ack_psn, ack_syn, ack_msn, ack_ip};
            if (ack_valid && ack_ready) begin
                ack_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL ack_unexpected: got psn %0h with nothing expected", ack_psn);
                end else begin
                    if ({ack_psn, ack_syn, ack_msn, ack_ip} !== exp_q[0]) begin
                        n_errors++;
                        $display("FAIL ack_fields: got %0h expected %0h",
                                 {ack_psn, ack_syn, ack_msn, ack_ip}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_hdr(pkt_t p, bit rnd);
        bit hs;
        int k;
        hdr_valid = 1'b1; src_ip = p.ip; src_port = 16'(49152 + $urandom_range(0, 999));
        dst_port = p.port; udp_len = p.len;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            hs = hdr_ready;
            @(posedge clk);
            #1;
            if (rnd) ack_ready = ($urandom_range(0, 2) != 0);
            if (hs) break;
        end
        if (k == 300) check("hdr_timeout", 1, 0);
        hdr_valid = 1'b0;
    endtask

    task automatic do_beat(logic [63:0] data, logic [7:0] keep, bit last, bit user,
                           int gap, bit rnd);
        bit hs;
        int k;
        for (int g = 0; g < gap; g++) begin
            tvalid = 1'b0; tdata = {$urandom, $urandom}; tlast = 1'($urandom);
            tuser = 1'($urandom);
            sync();
            if (rnd) ack_ready = ($urandom_range(0, 2) != 0);
        end
        tvalid = 1'b1; tdata = data; tkeep = keep; tlast = last; tuser = user;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            hs = tready;
            @(posedge clk);
            #1;
            if (rnd) ack_ready = ($urandom_range(0, 2) != 0);
            if (hs) break;
        end
        if (k == 300) check("beat_timeout", 1, 0);
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    endtask

    function automatic logic [63:0] beat0(pkt_t p);
        return {p.qp[7:0], p.qp[15:8], p.qp[23:16], 8'h00, 16'hFFFF, 8'h40, p.opcode};
    endfunction

    function automatic logic [63:0] beat1(pkt_t p);
        return {p.msn[7:0], p.msn[15:8], p.msn[23:16], p.syn,
                p.psn[7:0], p.psn[15:8], p.psn[23:16], 8'h80};
    endfunction

    task automatic send_pkt(pkt_t p, int gap, bit rnd);
        logic [63:0] data;
        logic [7:0]  keep;
        int          g;
        if (model_ok(p)) begin
            exp_q.push_back({p.psn, p.syn, p.msn, p.ip});
            exp_ack_tot++;
        end else begin
            exp_drop_tot++;
        end
        if (p.nbeats < 3) exp_early_tot++;
        do_hdr(p, rnd);
        for (int b = 0; b < p.nbeats; b++) begin
            if (b == 0) data = beat0(p);
            else if (b == 1) data = beat1(p);
            else data = {$urandom, $urandom};
            keep = (b == p.nbeats - 1 && b >= 2) ? 8'h0F : 8'hFF;
            g = (b == 0) ? 0 : (rnd ? int'($urandom_range(0, gap)) : gap);
            do_beat(data, keep, b == p.nbeats - 1, b == p.tuser_beat, g, rnd);
        end
    endtask

    task automatic check_idle_zero(string name);
        check(name, {ack_valid, hdr_ready, tready, busy, err_drop, err_early,
                     ack_psn, ack_syn, ack_msn, ack_ip}, '0);
    endtask

    initial begin : main
        pkt_t p;
        int   k;
        vecs[0]  = '{mk(4791, 28, 8'h11, 24'h16, 302, 8'h1F, 5, 32'h0BD40116, 3, -1), 0, 1, 0, 0};
        vecs[1]  = '{mk(4792, 28, 8'h11, 24'h16, 11, 8'h00, 1, 32'h01020304, 3, -1), 0, 0, 1, 0};
        vecs[2]  = '{mk(4791, 28, 8'h0A, 24'h16, 12, 8'h00, 2, 32'h01020304, 3, -1), 0, 0, 1, 0};
        vecs[3]  = '{mk(4791, 28, 8'h11, 24'h17, 13, 8'h00, 3, 32'h01020304, 3, -1), 0, 0, 1, 0};
        vecs[4]  = '{mk(4791, 28, 8'h11, 24'h16, 14, 8'h00, 4, 32'h01020304, 3, 2), 0, 0, 1, 0};
        vecs[5]  = '{mk(4791, 28, 8'h11, 24'h16, 15, 8'h00, 5, 32'h01020304, 2, -1), 0, 0, 1, 1};
        vecs[6]  = '{mk(4791, 28, 8'h11, 24'h16, 400, 8'h1F, 6, 32'h0A000001, 3, -1), 0, 1, 0, 0};
        vecs[7]  = '{mk(4791, 28, 8'h11, 24'h16, 16, 8'h00, 7, 32'h01020304, 1, -1), 0, 0, 1, 1};
        vecs[8]  = '{mk(4791, 36, 8'h11, 24'h16, 17, 8'h00, 8, 32'h01020304, 4, -1), 0, 0, 1, 0};
        vecs[9]  = '{mk(4791, 28, 8'h11, 24'h16, 24'hABCDEF, 8'h20, 24'h123456, 32'hC0A80001, 4, -1), 0, 1, 0, 0};
        vecs[10] = '{mk(4791, 28, 8'h11, 24'h16, 18, 8'h00, 9, 32'h01020304, 3, 0), 0, 0, 1, 0};
        vecs[11] = '{mk(4791, 28, 8'h11, 24'h16, 24'h0FFFFF, 8'h60, 24'hFFFFFE, 32'hFFFFFFFF, 3, -1), 2, 1, 0, 0};

        // Reset state, then header ready rises one edge after release.
        #2;
        check_idle_zero("reset_outputs");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("hdr_ready_before_edge", hdr_ready, 0);
        @(negedge clk);
        check("hdr_ready_idle", hdr_ready, 1);
        check("busy_idle", busy, 0);
        sync();

        for (int i = 0; i < 12; i++) begin
            send_pkt(vecs[i].p, vecs[i].gap, 0);
            @(negedge clk);
            check($sformatf("v%0d_valid", i), ack_valid, vecs[i].exp_ack);
            check($sformatf("v%0d_drop", i), err_drop, vecs[i].exp_drop);
            check($sformatf("v%0d_early", i), err_early, vecs[i].exp_early);
            check($sformatf("v%0d_busy", i), busy, 0);
            sync();
        end

        // Backpressure: second ACK waits behind the pending one.
        ack_ready = 1'b0;
        send_pkt(mk(4791, 28, 8'h11, 24'h16, 302, 8'h1F, 5, 32'h0BD40116, 3, -1), 0, 0);
        bp_done = 0;
        fork
            begin
                send_pkt(mk(4791, 28, 8'h11, 24'h16, 303, 8'h1F, 6, 32'h0BD40116, 3, -1), 0, 0);
                bp_done = 1;
            end
        join_none
        repeat (4) begin
            @(negedge clk);
            check("bp_hdr_blocked", {hdr_ready, ack_valid, ack_psn}, {1'b0, 1'b1, 24'd302});
        end
        sync();
        ack_ready = 1'b1;
        for (k = 0; k < 300 && !bp_done; k++) @(posedge clk);
        check("bp_done", bp_done, 1);
        sync();
        repeat (3) sync();
        check("bp_drained", exp_q.size(), 0);

        // Async reset in the middle of the AETH beat.
        p = mk(4791, 28, 8'h11, 24'h16, 77, 8'h00, 1, 32'h05060708, 3, -1);
        do_hdr(p, 0);
        do_beat(beat0(p), 8'hFF, 0, 0, 0, 0);
        tvalid = 1'b1; tdata = beat1(p); tlast = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("midpkt_reset_outputs");
        tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("post_reset_hdr_ready", hdr_ready, 1);
        sync();
        send_pkt(mk(4791, 28, 8'h11, 24'h16, 500, 8'h1F, 9, 32'h0BD40116, 3, -1), 0, 0);
        @(negedge clk);
        check("post_reset_valid", {ack_valid, ack_psn}, {1'b1, 24'd500});
        sync();

        // Randomized packets with stalls and random consumer backpressure.
        for (int i = 0; i < 60; i++) begin
            p.port   = ($urandom_range(0, 7) == 0) ? 16'(4790 + $urandom_range(0, 2)) : 16'd4791;
            p.len    = ($urandom_range(0, 7) == 0) ? 16'(20 + $urandom_range(0, 16)) : 16'd28;
            p.opcode = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(6, 18)) : 8'h11;
            p.qp     = ($urandom_range(0, 7) == 0) ? 24'($urandom) : LOC_QPN;
            p.psn    = 24'($urandom);
            p.syn    = 8'($urandom);
            p.msn    = 24'($urandom);
            p.ip     = $urandom;
            k        = $urandom_range(0, 9);
            p.nbeats = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : 3;
            p.tuser_beat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, p.nbeats - 1)) : -1;
            send_pkt(p, 2, 1);
        end
        ack_ready = 1'b1;
        repeat (5) sync();

        check("final_queue_empty", exp_q.size(), 0);
        check("final_drop_count", drop_cnt, exp_drop_tot);
        check("final_early_count", early_cnt, exp_early_tot);
        check("final_ack_count", ack_cnt, exp_ack_tot);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
